// File: rtl/framebuffer_reader_if.sv
// RAM read port and pixel stream of the framebuffer reader.
// master = reader side, slave = RAM/serializer side.
interface framebuffer_reader_if #(
  parameter int unsigned RAM_ADDR_WIDTH = 32,
  parameter int unsigned RAM_DATA_WIDTH = 16
);
  logic [RAM_ADDR_WIDTH-1:0] ram_addr;
  logic                      ram_read_enable;
  logic [RAM_DATA_WIDTH-1:0] ram_data;
  logic [RAM_DATA_WIDTH-1:0] pixel_data;
  logic                      pixel_valid;
  logic                      pixel_ready;

  modport master (
    output ram_addr, ram_read_enable, pixel_data, pixel_valid,
    input  ram_data, pixel_ready
  );

  modport slave (
    input  ram_addr, ram_read_enable, pixel_data, pixel_valid,
    output ram_data, pixel_ready
  );
endinterface

// File: rtl/framebuffer_reader.sv
// Reads one image per slice_start from a ring of RAM slots and streams it out through a 2-entry FIFO.
// Optional statistics counters are built when FB_READER_STATS_EN is defined.
module framebuffer_reader #(
  parameter int unsigned RAM_ADDR_WIDTH = 32,
  parameter int unsigned RAM_DATA_WIDTH = 16,
  parameter int unsigned IMAGE_SIZE     = 3840,
  parameter int unsigned IMAGE_IN_RAM   = 3
) (
  input  logic                clk_i,
  input  logic                nrst_i,
  input  logic                stream_ready_i,
  input  logic [1:0]          writer_slot_i,
  input  logic                slice_start_i,
  output logic                slice_done_o,
  output logic                slot_repeat_o,
  output logic [15:0]         stat_repeats_o,
  output logic [15:0]         stat_dropped_starts_o,
  framebuffer_reader_if.master bus_io
);
  localparam int unsigned CntW = $clog2(IMAGE_SIZE + 1);

  typedef enum logic [1:0] {StIdle, StWait, StRead, StDrain} state_e;

  state_e                    state_q;
  logic [1:0]                slot_q;
  logic [RAM_ADDR_WIDTH-1:0] base_q;
  logic [CntW-1:0]           issue_q;
  logic                      inflight_q;
  logic [RAM_DATA_WIDTH-1:0] fifo_q [2];
  logic                      wr_ptr_q, rd_ptr_q;
  logic [1:0]                fifo_cnt_q;
  logic                      slice_done_q, slot_repeat_q;

  logic                      push, pop, rd_en, drained;
  logic [1:0]                next_slot;
  logic [RAM_ADDR_WIDTH-1:0] next_base;

  assign push = inflight_q;
  assign pop  = (fifo_cnt_q != 2'd0) && bus_io.pixel_ready;
  // Counting this cycle's pop as freed space sustains one pixel per cycle.
  assign rd_en = (state_q == StRead) &&
                 (({1'b0, fifo_cnt_q} + {2'b0, inflight_q} - {2'b0, pop}) < 3'd2);
  assign drained   = (state_q == StDrain) && (fifo_cnt_q == 2'd0) && !inflight_q;
  assign next_slot = (slot_q == 2'(IMAGE_IN_RAM - 1)) ? 2'd0 : slot_q + 2'd1;
  assign next_base = RAM_ADDR_WIDTH'(slot_q) * RAM_ADDR_WIDTH'(IMAGE_SIZE);

  always_ff @(posedge clk_i) begin
    if (!nrst_i) begin
      state_q       <= StIdle;
      slot_q        <= 2'd0;
      base_q        <= '0;
      issue_q       <= '0;
      inflight_q    <= 1'b0;
      fifo_q[0]     <= '0;
      fifo_q[1]     <= '0;
      wr_ptr_q      <= 1'b0;
      rd_ptr_q      <= 1'b0;
      fifo_cnt_q    <= 2'd0;
      slice_done_q  <= 1'b0;
      slot_repeat_q <= 1'b0;
    end else begin
      slice_done_q  <= 1'b0;
      slot_repeat_q <= 1'b0;
      inflight_q    <= rd_en;
      if (rd_en) issue_q <= issue_q + CntW'(1);
      if (push) begin
        fifo_q[wr_ptr_q] <= bus_io.ram_data;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      fifo_cnt_q <= fifo_cnt_q + {1'b0, push} - {1'b0, pop};

      unique case (state_q)
        StIdle: if (stream_ready_i) state_q <= StWait;
        StWait: begin
          if (!stream_ready_i) begin
            state_q <= StIdle;
          end else if (slice_start_i && !slice_done_q) begin
            base_q  <= next_base;
            issue_q <= '0;
            state_q <= StRead;
          end
        end
        StRead: if (rd_en && issue_q == CntW'(IMAGE_SIZE - 1)) state_q <= StDrain;
        StDrain: begin
          if (drained) begin
            slice_done_q <= 1'b1;
            // Never step onto the slot the writer is filling.
            if (next_slot == writer_slot_i) slot_repeat_q <= 1'b1;
            else                            slot_q        <= next_slot;
            state_q <= stream_ready_i ? StWait : StIdle;
          end
        end
      endcase
    end
  end

  assign bus_io.ram_read_enable = rd_en;
  assign bus_io.ram_addr        = rd_en ? base_q + RAM_ADDR_WIDTH'(issue_q) : '0;
  assign bus_io.pixel_valid     = (fifo_cnt_q != 2'd0);
  assign bus_io.pixel_data      = (fifo_cnt_q != 2'd0) ? fifo_q[rd_ptr_q] : '0;
  assign slice_done_o           = slice_done_q;
  assign slot_repeat_o          = slot_repeat_q;

`ifdef FB_READER_STATS_EN
  logic [15:0] stat_repeats_q, stat_dropped_q;
  logic        drop;

  assign drop = slice_start_i &&
                ((state_q == StRead) || (state_q == StDrain) || slice_done_q);

  always_ff @(posedge clk_i) begin
    if (!nrst_i) begin
      stat_repeats_q <= 16'd0;
      stat_dropped_q <= 16'd0;
    end else begin
      if (slot_repeat_q && stat_repeats_q != 16'hFFFF) stat_repeats_q <= stat_repeats_q + 16'd1;
      if (drop && stat_dropped_q != 16'hFFFF)          stat_dropped_q <= stat_dropped_q + 16'd1;
    end
  end

  assign stat_repeats_o        = stat_repeats_q;
  assign stat_dropped_starts_o = stat_dropped_q;
`else
  assign stat_repeats_o        = 16'd0;
  assign stat_dropped_starts_o = 16'd0;
`endif
endmodule
